// File: rtl/npc_btb_fetch.sv
// Next-PC unit for IF: owns the fetch PC and a direct-mapped BTB with saturating direction counters.
// Latency: lookup is combinational from the pc register; the next PC and BTB updates take effect at the next rising edge.
// Backpressure: stall holds pc; exc_valid and redirect_valid override stall; BTB updates ignore stall.
module npc_btb_fetch #(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_3000,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR  = 32'h0000_4180,
    parameter int                  BTB_ENTRIES = 8,
    parameter int                  CNT_WIDTH   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                exc_valid,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_4,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_target,
    output logic                btb_hit
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = PC_WIDTH - 2 - IDX_W;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

    typedef struct packed {
        logic                 vld;
        logic [TAG_W-1:0]     tag;
        logic [PC_WIDTH-1:0]  target;
        logic [CNT_WIDTH-1:0] cnt;
    } btb_entry_t;

    btb_entry_t btb [BTB_ENTRIES];

    // Lookup side, driven purely by the registered pc.
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    btb_entry_t       rd_ent;

    assign rd_idx      = pc[2 +: IDX_W];
    assign rd_tag      = pc[PC_WIDTH-1 -: TAG_W];
    assign rd_ent      = btb[rd_idx];
    assign pc_4        = pc + PC_WIDTH'(4);
    assign btb_hit     = rd_ent.vld && (rd_ent.tag == rd_tag);
    assign pred_taken  = btb_hit && rd_ent.cnt[CNT_WIDTH-1];
    assign pred_target = pred_taken ? rd_ent.target : pc_4;

    // Update side: resolved branches from EX.
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_ent;
    btb_entry_t       upd_nxt;
    logic             upd_hit;
    logic             upd_we;

    assign upd_idx = upd_pc[2 +: IDX_W];
    assign upd_tag = upd_pc[PC_WIDTH-1 -: TAG_W];
    assign upd_ent = btb[upd_idx];
    assign upd_hit = upd_ent.vld && (upd_ent.tag == upd_tag);

    // Byte-offset bits of instruction addresses carry no information here.
    logic unused_low_bits;
    assign unused_low_bits = ^{upd_pc[1:0], redirect_pc[1:0]};

    always_comb begin
        upd_we  = 1'b0;
        upd_nxt = upd_ent;
        if (upd_valid) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (upd_taken) begin
                    upd_nxt.target = upd_target;
                    if (upd_ent.cnt != CNT_MAX) begin
                        upd_nxt.cnt = upd_ent.cnt + CNT_WIDTH'(1);
                    end
                end else if (upd_ent.cnt != CNT_ZERO) begin
                    upd_nxt.cnt = upd_ent.cnt - CNT_WIDTH'(1);
                end
            end else if (upd_taken) begin
                // Miss on a taken branch replaces whatever aliases into this slot.
                upd_we         = 1'b1;
                upd_nxt.vld    = 1'b1;
                upd_nxt.tag    = upd_tag;
                upd_nxt.target = upd_target;
                upd_nxt.cnt    = CNT_WEAK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i] <= '0;
            end
        end else if (upd_we) begin
            btb[upd_idx] <= upd_nxt;
        end
    end

    logic [PC_WIDTH-1:0] pc_nxt;

    always_comb begin
        pc_nxt = pred_target;
        if (exc_valid) begin
            pc_nxt = EXC_VECTOR;
        end else if (redirect_valid) begin
            pc_nxt = {redirect_pc[PC_WIDTH-1:2], 2'b00};
        end else if (stall) begin
            pc_nxt = pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_npc_btb_fetch.sv
// Randomized and directed bench for npc_btb_fetch with a queue-based scoreboard.
module tb_npc_btb_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;
    localparam int          NENT   = 8;
    localparam int          CW     = 2;
    localparam int          CMAX   = (1 << CW) - 1;
    localparam int          CHALF  = 1 << (CW - 1);

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, exc_valid, redirect_valid, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [31:0] pc, pc_4, pred_target;
    logic        pred_taken, btb_hit;

    always #5 clk = ~clk;

    npc_btb_fetch #(
        .PC_WIDTH(32), .RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC),
        .BTB_ENTRIES(NENT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .exc_valid(exc_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .pc(pc), .pc_4(pc_4), .pred_taken(pred_taken),
        .pred_target(pred_target), .btb_hit(btb_hit)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] tgt;
        logic        hit;
        logic        taken;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Reference model: a table of entries addressed by word index modulo NENT.
    logic [31:0] m_pc;
    logic        m_vld [NENT];
    logic [31:0] m_tag [NENT];
    logic [31:0] m_tgt [NENT];
    int          m_cnt [NENT];

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % NENT);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] a);
        return a / (4 * NENT);
    endfunction

    task automatic m_reset();
        m_pc = RST_PC;
        for (int i = 0; i < NENT; i++) begin
            m_vld[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
        end
    endtask

    task automatic m_lookup(input logic [31:0] a, output logic hit, output logic tk, output logic [31:0] tgt);
        int i;
        i   = idx_of(a);
        hit = m_vld[i] && (m_tag[i] == tag_of(a));
        tk  = hit && (m_cnt[i] >= CHALF);
        tgt = tk ? m_tgt[i] : a + 32'd4;
    endtask

    task automatic m_step(input logic s, input logic e, input logic r, input logic [31:0] rpc,
                          input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        logic hit, tk, uhit;
        logic [31:0] tgt, nxt;
        int i;
        m_lookup(m_pc, hit, tk, tgt);
        if (e)      nxt = EXC_PC;
        else if (r) nxt = rpc - (rpc % 4);
        else if (s) nxt = m_pc;
        else        nxt = tgt;
        if (uv) begin
            i    = idx_of(upc);
            uhit = m_vld[i] && (m_tag[i] == tag_of(upc));
            if (uhit && ut) begin
                m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                m_tgt[i] = utg;
            end else if (uhit) begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end else if (ut) begin
                m_vld[i] = 1'b1; m_tag[i] = tag_of(upc); m_tgt[i] = utg; m_cnt[i] = CHALF;
            end
        end
        m_pc = nxt;
    endtask

    // Called at posedge+1; drives one cycle of inputs and queues that cycle's expected outputs.
    task automatic cycle(input logic s, input logic e, input logic r, input logic [31:0] rpc,
                         input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        exp_t x;
        stall = s; exc_valid = e; redirect_valid = r; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        x.pc = m_pc;
        x.pc_4 = m_pc + 32'd4;
        m_lookup(m_pc, x.hit, x.taken, x.tgt);
        sb_q.push_back(x);
        @(posedge clk);
        m_step(s, e, r, rpc, uv, upc, ut, utg);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redir(input logic [31:0] a);
        cycle(1'b0, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic upd_stalled(input logic [31:0] a, input logic t, input logic [31:0] tg);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, a, t, tg);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t x;
            x = sb_q.pop_front();
            chk("mon_pc", pc, x.pc);
            chk("mon_pc_4", pc_4, x.pc_4);
            chk("mon_btb_hit", {31'b0, btb_hit}, {31'b0, x.hit});
            chk("mon_pred_taken", {31'b0, pred_taken}, {31'b0, x.taken});
            chk("mon_pred_target", pred_target, x.tgt);
        end
    end

    initial begin
        reset_n = 1'b0;
        stall = 0; exc_valid = 0; redirect_valid = 0; redirect_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, RST_PC);
        chk("reset_hit", {31'b0, btb_hit}, 32'd0);
        chk("reset_taken", {31'b0, pred_taken}, 32'd0);
        chk("reset_pred_target", pred_target, RST_PC + 32'd4);
        reset_n = 1'b1;

        idle(); chk("seq_pc1", pc, 32'h3004);
        idle(); chk("seq_pc2", pc, 32'h3008);

        // Allocation: the lookup in the update cycle still sees the old (empty) entry.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3008, 1'b1, 32'h3100);
        chk("alloc_same_cycle_pc", pc, 32'h300C);
        redir(32'h3008);
        chk("alloc_hit", {31'b0, btb_hit}, 32'd1);
        chk("alloc_taken", {31'b0, pred_taken}, 32'd1);
        chk("alloc_target", pred_target, 32'h3100);
        idle(); chk("alloc_follow", pc, 32'h3100);

        repeat (4) upd_stalled(32'h3008, 1'b0, 32'h0);
        redir(32'h3008);
        chk("sat_low_hit", {31'b0, btb_hit}, 32'd1);
        chk("sat_low_taken", {31'b0, pred_taken}, 32'd0);
        chk("sat_low_target", pred_target, 32'h300C);
        idle(); chk("sat_low_next", pc, 32'h300C);

        repeat (2) upd_stalled(32'h3008, 1'b1, 32'h3100);
        redir(32'h3008);
        chk("weak_taken", {31'b0, pred_taken}, 32'd1);
        repeat (6) upd_stalled(32'h3008, 1'b1, 32'h3100);
        upd_stalled(32'h3008, 1'b0, 32'h0);
        chk("sat_high_one_nt", {31'b0, pred_taken}, 32'd1);
        upd_stalled(32'h3008, 1'b0, 32'h0);
        chk("sat_high_two_nt", {31'b0, pred_taken}, 32'd0);

        cycle(1'b1, 1'b0, 1'b1, 32'h3203, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("prio_redirect", pc, 32'h3200);
        cycle(1'b1, 1'b1, 1'b1, 32'h3203, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("prio_exc", pc, EXC_PC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_hold1", pc, EXC_PC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_hold2", pc, EXC_PC);

        upd_stalled(32'h3028, 1'b1, 32'h3300);
        redir(32'h3008);
        chk("alias_old_hit", {31'b0, btb_hit}, 32'd0);
        chk("alias_old_target", pred_target, 32'h300C);
        redir(32'h3028);
        chk("alias_new_target", pred_target, 32'h3300);

        redir(32'hFFFF_FFFC);
        chk("wrap_pc_4", pc_4, 32'h0);
        chk("wrap_hit", {31'b0, btb_hit}, 32'd0);
        idle(); chk("wrap_next", pc, 32'h0);

        // Reset pulse between edges, with an update and redirect pending across the edge.
        @(negedge clk);
        #1;
        upd_valid = 1; upd_pc = 32'h3040; upd_taken = 1; upd_target = 32'h3500;
        redirect_valid = 1; redirect_pc = 32'h3400;
        reset_n = 1'b0;
        #1;
        chk("async_reset_pc", pc, RST_PC);
        chk("async_reset_hit", {31'b0, btb_hit}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_held_pc", pc, RST_PC);
        reset_n = 1'b1;
        m_reset();
        redir(32'h3028);
        chk("post_reset_old_entry", {31'b0, btb_hit}, 32'd0);
        redir(32'h3040);
        chk("post_reset_dropped_upd", {31'b0, btb_hit}, 32'd0);

        for (int n = 0; n < 800; n++) begin
            logic s, e, r, uv, ut;
            logic [31:0] rpc, upc, utg;
            s   = ($urandom_range(99, 0) < 20);
            e   = ($urandom_range(99, 0) < 3);
            r   = ($urandom_range(99, 0) < 10);
            rpc = ($urandom_range(99, 0) < 5) ? 32'hFFFF_FFFC : 32'h3000 + $urandom_range(255, 0);
            uv  = ($urandom_range(99, 0) < 45);
            upc = 32'h3000 + 4 * $urandom_range(31, 0);
            ut  = $urandom_range(1, 0);
            utg = 32'h3000 + 4 * $urandom_range(63, 0);
            cycle(s, e, r, rpc, uv, upc, ut, utg);
            // Keep the fetch stream inside the region the BTB is trained on.
            if (m_pc > 32'h3100 && m_pc != EXC_PC && m_pc < 32'hFFFF_0000) redir(32'h3000);
        end

        idle();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
